// File: rtl/mult_add_iter_if.sv
// rtl/mult_add_iter_if.sv - request/result bundle for the iterative multiply-add unit
interface mult_add_iter_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0] quotient_in;
  logic [WIDTH-1:0] divisor_in;
  logic [WIDTH-1:0] remainder_in;
  logic             data_valid_in;
  logic [WIDTH-1:0] dividend_out;
  logic             data_valid_out;
  logic             error_out;
  logic             busy_out;

  modport master (
    output quotient_in, divisor_in, remainder_in, data_valid_in,
    input  dividend_out, data_valid_out, error_out, busy_out
  );

  modport slave (
    input  quotient_in, divisor_in, remainder_in, data_valid_in,
    output dividend_out, data_valid_out, error_out, busy_out
  );
endinterface

// File: rtl/mult_add_iter.sv
// rtl/mult_add_iter.sv - iterative shift-add q*d + r, inverse of the restoring divider
module mult_add_iter #(
  parameter int WIDTH = 64
) (
  input logic           clk_in,
  input logic           rst_n_in,
  mult_add_iter_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               armed;
  logic [WIDTH-1:0]   q_r;
  logic [WIDTH-1:0]   d_r;
  logic [WIDTH-1:0]   r_r;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   res_r;
  logic               err_r;
  logic               dv_r;
  logic               overflow;
  logic               bad_rem;

  // One LSB-first partial product per step; full 2*WIDTH accumulator so the
  // overflow check sees every carry out of the result width.
  always_comb begin
    acc_next = acc;
    if (q_r[cnt]) begin
      acc_next = acc + ({{WIDTH{1'b0}}, d_r} << cnt);
    end
  end

  assign overflow = |acc_next[2*WIDTH-1:WIDTH];
  // A remainder not below its divisor can never come out of the divider;
  // d=0 is accepted and only the overflow rule applies then.
  assign bad_rem  = (d_r != '0) && (r_r >= d_r);

  // Control FSM, operand capture, accumulation and result registers.
  // armed keeps the first edge after reset release from capturing a request.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= S_IDLE;
      cnt   <= '0;
      armed <= 1'b0;
      q_r   <= '0;
      d_r   <= '0;
      r_r   <= '0;
      acc   <= '0;
      res_r <= '0;
      err_r <= 1'b0;
      dv_r  <= 1'b0;
    end else begin
      armed <= 1'b1;
      dv_r  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.data_valid_in && armed) begin
            q_r   <= bus.quotient_in;
            d_r   <= bus.divisor_in;
            r_r   <= bus.remainder_in;
            acc   <= {{WIDTH{1'b0}}, bus.remainder_in};
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            res_r <= acc_next[WIDTH-1:0];
            err_r <= overflow | bad_rem;
            dv_r  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.dividend_out   = res_r;
  assign bus.error_out      = err_r;
  assign bus.data_valid_out = dv_r;
  assign bus.busy_out       = (state != S_IDLE);
endmodule

// File: tb/tb_mult_add_iter.sv
// tb/tb_mult_add_iter.sv - directed vector bench for mult_add_iter
module tb_mult_add_iter;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mult_add_iter_if #(.WIDTH(W)) bus ();
  mult_add_iter #(.WIDTH(W)) dut (.clk_in(clk), .rst_n_in(rst_n), .bus(bus));

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] d;
    logic [W-1:0] r;
    logic [W-1:0] res;
    logic         err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Issue one request and watch W+4 cycles after the capture edge.
  task automatic do_op(input vec_t v, input int idx);
    int dv_at;
    int pulses;
    int busy_cnt;
    logic [W-1:0] res;
    logic err;
    dv_at = -1; pulses = 0; busy_cnt = 0; res = '0; err = 1'b0;
    @(negedge clk);
    bus.quotient_in = v.q; bus.divisor_in = v.d; bus.remainder_in = v.r;
    bus.data_valid_in = 1'b1;
    @(posedge clk);
    #1 bus.data_valid_in = 1'b0;
    for (int k = 0; k < W + 4; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (bus.busy_out) busy_cnt++;
      if (bus.data_valid_out) begin
        pulses++;
        dv_at = k;
        res = bus.dividend_out;
        err = bus.error_out;
      end
    end
    check($sformatf("v%0d_result", idx), 64'(res), 64'(v.res));
    check($sformatf("v%0d_error", idx), 64'(err), 64'(v.err));
    check($sformatf("v%0d_pulses", idx), 64'(pulses), 64'd1);
    check($sformatf("v%0d_dv_cycle", idx), 64'(dv_at), 64'(W));
    check($sformatf("v%0d_busy_cycles", idx), 64'(busy_cnt), 64'(W + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int pulses;
    int cap;
    int full;
    int qx, dx, rx;

    vecs[0] = '{q: 8'd13,  d: 8'd7,   r: 8'd5,  res: 8'd96,  err: 1'b0};
    vecs[1] = '{q: 8'd255, d: 8'd255, r: 8'd0,  res: 8'd1,   err: 1'b1};
    vecs[2] = '{q: 8'd0,   d: 8'd0,   r: 8'd0,  res: 8'd0,   err: 1'b0};
    vecs[3] = '{q: 8'd1,   d: 8'd7,   r: 8'd9,  res: 8'd16,  err: 1'b1};
    vecs[4] = '{q: 8'd3,   d: 8'd0,   r: 8'd4,  res: 8'd4,   err: 1'b0};
    vecs[5] = '{q: 8'd10,  d: 8'd20,  r: 8'd5,  res: 8'd205, err: 1'b0};
    vecs[6] = '{q: 8'd16,  d: 8'd16,  r: 8'd15, res: 8'd15,  err: 1'b1};
    vecs[7] = '{q: 8'd2,   d: 8'd5,   r: 8'd5,  res: 8'd15,  err: 1'b1};
    vecs[8] = '{q: 8'd255, d: 8'd1,   r: 8'd0,  res: 8'd255, err: 1'b0};
    vecs[9] = '{q: 8'd255, d: 8'd2,   r: 8'd1,  res: 8'd255, err: 1'b1};

    bus.quotient_in = '0; bus.divisor_in = '0; bus.remainder_in = '0;
    bus.data_valid_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dividend", 64'(bus.dividend_out), 64'd0);
    check("rst_dv", 64'(bus.data_valid_out), 64'd0);
    check("rst_error", 64'(bus.error_out), 64'd0);
    check("rst_busy", 64'(bus.busy_out), 64'd0);
    bus.data_valid_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 10; i++) do_op(vecs[i], i);

    // Request held high with operands changing every cycle.
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      bus.quotient_in = 8'(n + 3); bus.divisor_in = 8'(n + 11); bus.remainder_in = 8'd2;
      bus.data_valid_in = 1'b1;
      @(posedge clk);
      #1;
      if (bus.data_valid_out) begin
        cap = pulses * (W + 2);
        qx = cap + 3; dx = cap + 11; rx = 2;
        full = qx * dx + rx;
        check($sformatf("hold%0d_cycle", pulses), 64'(n), 64'(cap + W));
        check($sformatf("hold%0d_result", pulses), 64'(bus.dividend_out), 64'(full % 256));
        check($sformatf("hold%0d_error", pulses), 64'(bus.error_out),
              64'((full > 255) || (dx != 0 && rx >= dx)));
        pulses++;
      end
    end
    check("hold_pulses", 64'(pulses), 64'd4);
    @(negedge clk);
    bus.data_valid_in = 1'b0;
    repeat (3) @(posedge clk);

    // Abort mid-run with asynchronous reset.
    @(negedge clk);
    bus.quotient_in = 8'd13; bus.divisor_in = 8'd7; bus.remainder_in = 8'd5;
    bus.data_valid_in = 1'b1;
    @(posedge clk);
    #1 bus.data_valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_dividend", 64'(bus.dividend_out), 64'd0);
    check("abort_busy", 64'(bus.busy_out), 64'd0);
    check("abort_dv", 64'(bus.data_valid_out), 64'd0);
    check("abort_error", 64'(bus.error_out), 64'd0);
    bus.data_valid_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("abort_busy_in_reset", 64'(bus.busy_out), 64'd0);
    bus.data_valid_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < W + 6; k++) begin
      @(posedge clk);
      #1;
      if (bus.data_valid_out) pulses++;
    end
    check("abort_no_pulse", 64'(pulses), 64'd0);
    do_op(vecs[0], 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mult_add_iter.md
MULT_ADD_ITER -- requirements
Module: mult_add_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand and result width in bits (legal range 2..64).
REQ-002 SHALL have port clk_in  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n_in  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port quotient_in  input  WIDTH  multiplier operand q.
REQ-005 SHALL have port divisor_in  input  WIDTH  multiplicand operand d.
REQ-006 SHALL have port remainder_in  input  WIDTH  addend r.
REQ-007 SHALL have port data_valid_in  input  1  request strobe, sampled on rising edge.
REQ-008 SHALL have port dividend_out  output  WIDTH  result (q*d + r) mod 2^WIDTH.
REQ-009 SHALL have port data_valid_out  output  1  one-cycle completion pulse.
REQ-010 SHALL have port error_out  output  1  overflow/inconsistency flag for the current result.
REQ-011 SHALL have port busy_out  output  1  high while an operation is in flight.

Function
REQ-012 SHALL compute dividend_out = low WIDTH bits of q*d + r, inverting the team's restoring divider (q, r from dividend/d).
REQ-013 SHALL use an FSM with states IDLE, RUN, DONE.
REQ-014 SHALL, in IDLE with data_valid_in=1 at edge E0, capture q, d, r into internal registers, load a 2*WIDTH-bit accumulator with zero-extended r, clear iteration counter, and go to RUN.
REQ-015 SHALL, in RUN, perform one shift-add step per edge, LSB first: at step i (0..WIDTH-1), if q bit i = 1 then acc += zero-extended d << i.
REQ-016 SHALL move RUN -> DONE at the edge performing step WIDTH-1 (edge E0+WIDTH).
REQ-017 SHALL, in DONE, drive data_valid_out=1 for exactly one cycle, then move DONE -> IDLE at the next edge (edge E0+WIDTH+1).
REQ-018 SHALL have fixed latency: data_valid_out is high in the cycle following edge E0+WIDTH, independent of operand values (no early termination).
REQ-019 SHALL drive dividend_out and error_out from registers; values SHALL be valid when data_valid_out=1 and SHALL hold until the next completion updates them.
REQ-020 SHALL assert error_out when acc[2*WIDTH-1:WIDTH] != 0 (overflow) OR (d != 0 AND r >= d) (invalid remainder); consistency is checked on captured values.
REQ-021 SHALL treat d=0 as legal: result = r, error_out set only by overflow rule.
REQ-022 SHALL drive busy_out=1 in RUN and DONE, 0 in IDLE; busy_out SHALL rise in the cycle after E0.
REQ-023 SHALL ignore data_valid_in while in RUN or DONE: no capture, no queueing, no effect on in-flight operation.
REQ-024 SHALL accept a new request in the IDLE cycle immediately following DONE; maximum throughput one result per WIDTH+2 cycles.
REQ-025 SHALL make all arithmetic unsigned; accumulator SHALL never truncate before the error check.

Reset
REQ-026 SHALL, on rst_n_in=0, immediately force state IDLE, counter 0, accumulator 0, dividend_out 0, data_valid_out 0, error_out 0, busy_out 0.
REQ-027 SHALL abort any in-flight operation on reset with no later data_valid_out pulse for it.
REQ-028 SHALL ignore data_valid_in while rst_n_in=0 and in the edge on which rst_n_in deasserts.

Verification
REQ-029 WIDTH=8: q=13, d=7, r=5 at E0 -> dividend_out=96, error_out=0, data_valid_out high only in cycle after E0+8, busy_out high cycles E0+1..E0+9.
REQ-030 WIDTH=8: q=255, d=255, r=0 -> dividend_out=1 (65025 mod 256), error_out=1; q=0, d=0, r=0 -> dividend_out=0, error_out=0.
REQ-031 WIDTH=8: q=1, d=7, r=9 -> dividend_out=16, error_out=1 (r>=d); q=3, d=0, r=4 -> dividend_out=4, error_out=0.
REQ-032 data_valid_in held high continuously with changing operands -> captures only at IDLE edges, one result per WIDTH+2 cycles, each matching operands present at its capture edge.
REQ-033 rst_n_in pulsed low mid-RUN -> all outputs 0 asynchronously, no data_valid_out for aborted operation, next request after deassertion completes correctly.
REQ-034 WIDTH=64, 10k random dividends through the team divider then this block -> dividend_out equals original dividend, error_out=0 for every nonzero divisor.
